// File: rtl/loop_unit_pkg.sv
// Shared definitions for the bracket-loop control unit: FSM states and default sizes.
package loop_unit_pkg;

  localparam int LOOP_STACK_DEPTH = 16;
  localparam int PROGRAM_COUNTER  = 16;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    SKIP  = 2'd1,
    FAULT = 2'd2
  } loop_state_e;

endpackage

// File: rtl/loop_stack.sv
// LIFO return stack holding loop-open addresses; only the occupancy pointer is reset.
module loop_stack #(
  parameter  int DEPTH = 16,
  parameter  int W     = 16,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [W-1:0]  push_data,
  output logic [W-1:0]  top,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  logic [W-1:0]  mem_q [DEPTH];
  logic [CW-1:0] count_q, count_d;
  logic [AW-1:0] top_idx;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  // Wraps to DEPTH-1 when full; the empty case is masked below.
  assign top_idx = count_q[AW-1:0] - AW'(1);
  assign top     = empty ? '0 : mem_q[top_idx];

  always_comb begin
    count_d = count_q;
    if (push && !full)
      count_d = count_q + CW'(1);
    else if (pop && !empty)
      count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) count_q <= '0;
    else        count_q <= count_d;
  end

  always_ff @(posedge clk) begin
    if (push && !full) mem_q[count_q[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/loop_unit.sv
// Loop control for '[' / ']': return stack, zero-entry skip tracking and sticky fault.
module loop_unit
  import loop_unit_pkg::*;
#(
  parameter  int STACK_DEPTH = LOOP_STACK_DEPTH,
  parameter  int SKIP_W      = 8,
  localparam int DW          = $clog2(STACK_DEPTH) + 1
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       instr_valid,
  input  logic                       is_open,
  input  logic                       is_close,
  input  logic                       acc_zero,
  input  logic [PROGRAM_COUNTER-1:0] pc,
  output logic [PROGRAM_COUNTER-1:0] pc_loaded,
  output logic                       pc_take,
  output logic                       skip,
  output logic [DW-1:0]              depth,
  output logic                       fault,
  output loop_state_e                state_dbg
);

  loop_state_e                state_q, state_d;
  logic [SKIP_W-1:0]          skip_cnt_q, skip_cnt_d;
  logic                       active;
  logic                       push_en, pop_en;
  logic [PROGRAM_COUNTER-1:0] stk_top;
  logic [DW-1:0]              stk_count;
  logic                       stk_full, stk_empty;

  // instr_valid qualifies the opcode flags; there is no back-pressure, and a
  // cycle with both or neither bracket flag is a no-op.
  assign active = instr_valid && (is_open ^ is_close);

  loop_stack #(
    .DEPTH (STACK_DEPTH),
    .W     (PROGRAM_COUNTER)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_en),
    .pop       (pop_en),
    .push_data (pc),
    .top       (stk_top),
    .count     (stk_count),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RUN;
      skip_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      skip_cnt_q <= skip_cnt_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    skip_cnt_d = skip_cnt_q;
    if (active) begin
      case (state_q)
        RUN: begin
          if (is_open) begin
            if (stk_full) state_d = FAULT;
            else if (acc_zero) begin
              state_d    = SKIP;
              skip_cnt_d = SKIP_W'(1);
            end
          end else if (stk_empty) begin
            state_d = FAULT;
          end
        end
        SKIP: begin
          if (is_open) begin
            if (skip_cnt_q == '1) state_d = FAULT;
            else skip_cnt_d = skip_cnt_q + SKIP_W'(1);
          end else begin
            skip_cnt_d = skip_cnt_q - SKIP_W'(1);
            if (skip_cnt_q == SKIP_W'(1)) state_d = RUN;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    push_en = 1'b0;
    pop_en  = 1'b0;
    pc_take = 1'b0;
    if (active && state_q == RUN) begin
      if (is_open) begin
        push_en = !stk_full && !acc_zero;
      end else begin
        pop_en  = !stk_empty && acc_zero;
        pc_take = !stk_empty && !acc_zero;
      end
    end
  end

  assign pc_loaded = stk_empty ? '0 : stk_top + PROGRAM_COUNTER'(1);
  assign skip      = (state_q != RUN);
  assign fault     = (state_q == FAULT);
  assign depth     = stk_count;
  assign state_dbg = state_q;

endmodule

// File: tb/tb_loop_unit.sv
// Directed bench for loop_unit with a scoreboard of same-cycle and post-edge expectations.
module tb_loop_unit;
  import loop_unit_pkg::*;

  localparam logic [1:0] ST_RUN   = 2'd0;
  localparam logic [1:0] ST_SKIP  = 2'd1;
  localparam logic [1:0] ST_FAULT = 2'd2;

  logic        clk = 1'b0;
  logic        reset;
  logic        instr_valid, is_open, is_close, acc_zero;
  logic [15:0] pc, pc_loaded;
  logic        pc_take, skip, fault;
  logic [4:0]  depth;
  loop_state_e state_dbg;

  logic [16:0] exp_comb_q[$];
  logic [8:0]  exp_reg_q[$];
  int n_checks = 0;
  int n_fail   = 0;

  loop_unit dut (
    .clk         (clk),
    .reset       (reset),
    .instr_valid (instr_valid),
    .is_open     (is_open),
    .is_close    (is_close),
    .acc_zero    (acc_zero),
    .pc          (pc),
    .pc_loaded   (pc_loaded),
    .pc_take     (pc_take),
    .skip        (skip),
    .depth       (depth),
    .fault       (fault),
    .state_dbg   (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic v, input logic o, input logic c, input logic az,
                      input logic [15:0] p, input logic exp_take, input logic [15:0] exp_loaded,
                      input logic [1:0] exp_st, input logic [4:0] exp_depth, input string tag);
    logic [16:0] ec;
    logic [8:0]  er;
    @(negedge clk);
    instr_valid = v; is_open = o; is_close = c; acc_zero = az; pc = p;
    exp_comb_q.push_back({exp_take, exp_loaded});
    exp_reg_q.push_back({exp_st, exp_st == ST_FAULT, exp_st != ST_RUN, exp_depth});
    #1;
    ec = exp_comb_q.pop_front();
    chk({tag, " comb"}, {15'd0, pc_take, pc_loaded}, {15'd0, ec});
    @(posedge clk);
    #1;
    er = exp_reg_q.pop_front();
    chk({tag, " reg"}, {23'd0, 2'(state_dbg), fault, skip, depth}, {23'd0, er});
  endtask

  task automatic reset_check(input string tag);
    @(negedge clk);
    #2;
    reset = 1'b0;
    instr_valid = 1'b0;
    #1;
    chk(tag, {6'd0, pc_take, pc_loaded, 2'(state_dbg), fault, skip, depth},
        {6'd0, 1'b0, 16'h0000, ST_RUN, 1'b0, 1'b0, 5'd0});
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    instr_valid = 1'b0; is_open = 1'b0; is_close = 1'b0; acc_zero = 1'b0; pc = 16'h0;
    #12;
    chk("reset state", {6'd0, pc_take, pc_loaded, 2'(state_dbg), fault, skip, depth},
        {6'd0, 1'b0, 16'h0000, ST_RUN, 1'b0, 1'b0, 5'd0});
    @(negedge clk);
    reset = 1'b1;

    // Basic loop: push, take-back, exit
    step(1, 1, 0, 0, 16'd5, 0, 16'd0, ST_RUN, 5'd1, "open pc5");
    step(1, 0, 1, 0, 16'd9, 1, 16'd6, ST_RUN, 5'd1, "close loop back");
    step(1, 0, 1, 1, 16'd9, 0, 16'd6, ST_RUN, 5'd0, "close exit");

    // Inactive cycles leave everything alone
    step(1, 1, 0, 0, 16'd20, 0, 16'd0,  ST_RUN, 5'd1, "open pc20");
    step(0, 1, 0, 1, 16'd21, 0, 16'd21, ST_RUN, 5'd1, "invalid open");
    step(1, 1, 1, 0, 16'd22, 0, 16'd21, ST_RUN, 5'd1, "both flags az0");
    step(1, 1, 1, 1, 16'd22, 0, 16'd21, ST_RUN, 5'd1, "both flags az1");
    step(0, 0, 1, 0, 16'd23, 0, 16'd21, ST_RUN, 5'd1, "invalid close");
    step(1, 0, 0, 0, 16'd23, 0, 16'd21, ST_RUN, 5'd1, "no flags");
    step(1, 0, 1, 1, 16'd24, 0, 16'd21, ST_RUN, 5'd0, "close exit pc20");

    // Nested loops return to the inner then outer target
    step(1, 1, 0, 0, 16'd10, 0, 16'd0,  ST_RUN, 5'd1, "lifo open10");
    step(1, 1, 0, 0, 16'd30, 0, 16'd11, ST_RUN, 5'd2, "lifo open30");
    step(1, 0, 1, 0, 16'd35, 1, 16'd31, ST_RUN, 5'd2, "lifo inner back");
    step(1, 0, 1, 1, 16'd35, 0, 16'd31, ST_RUN, 5'd1, "lifo inner exit");
    step(1, 0, 1, 0, 16'd36, 1, 16'd11, ST_RUN, 5'd1, "lifo outer back");
    step(1, 0, 1, 1, 16'd36, 0, 16'd11, ST_RUN, 5'd0, "lifo outer exit");

    // Zero-entered loop with a nested pair inside
    step(1, 1, 0, 1, 16'd3, 0, 16'd0, ST_SKIP, 5'd0, "skip enter");
    step(1, 1, 0, 0, 16'd4, 0, 16'd0, ST_SKIP, 5'd0, "skip nest open");
    step(1, 0, 1, 0, 16'd5, 0, 16'd0, ST_SKIP, 5'd0, "skip nest close");
    step(1, 0, 1, 1, 16'd6, 0, 16'd0, ST_RUN,  5'd0, "skip final close");

    // Target adder wraps
    step(1, 1, 0, 0, 16'hFFFF, 0, 16'h0000, ST_RUN, 5'd1, "wrap open");
    step(1, 0, 1, 0, 16'h0002, 1, 16'h0000, ST_RUN, 5'd1, "wrap close back");
    step(1, 0, 1, 1, 16'h0002, 0, 16'h0000, ST_RUN, 5'd0, "wrap close exit");

    // Stack overflow
    for (int i = 0; i < 16; i++)
      step(1, 1, 0, 0, 16'(100 + i), 0, (i == 0) ? 16'd0 : 16'(100 + i), ST_RUN, 5'(i + 1), "fill open");
    step(1, 1, 0, 0, 16'd200, 0, 16'd116, ST_FAULT, 5'd16, "overflow open");
    step(1, 0, 1, 0, 16'd201, 0, 16'd116, ST_FAULT, 5'd16, "fault close ignored");
    step(1, 0, 1, 1, 16'd202, 0, 16'd116, ST_FAULT, 5'd16, "fault pop ignored");
    reset_check("async reset from overflow fault");

    // Underflow
    step(1, 0, 1, 0, 16'd7, 0, 16'd0, ST_FAULT, 5'd0, "underflow close");
    step(1, 1, 0, 0, 16'd8, 0, 16'd0, ST_FAULT, 5'd0, "fault open ignored");
    reset_check("async reset from underflow fault");

    // Async reset in the middle of a skip
    step(1, 1, 0, 1, 16'd50, 0, 16'd0, ST_SKIP, 5'd0, "skip enter again");
    reset_check("async reset from skip");

    // Skip-counter overflow at 255 nested opens
    step(1, 1, 0, 1, 16'd40, 0, 16'd0, ST_SKIP, 5'd0, "deep skip enter");
    for (int i = 2; i <= 255; i++)
      step(1, 1, 0, $urandom_range(0, 1), 16'(40 + i), 0, 16'd0, ST_SKIP, 5'd0, "deep skip open");
    step(1, 1, 0, 0, 16'd300, 0, 16'd0, ST_FAULT, 5'd0, "skip count overflow");
    reset_check("async reset from skip overflow");

    // Normal operation after reset
    step(1, 1, 0, 0, 16'd60, 0, 16'd0,  ST_RUN, 5'd1, "post reset open");
    step(1, 0, 1, 0, 16'd61, 1, 16'd61, ST_RUN, 5'd1, "post reset back");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/loop_unit.md
LOOP_UNIT -- requirements
Module: loop_unit

Interface
REQ-001 Parameter: STACK_DEPTH, default 16, number of return-stack entries (power of two, 2..64).
REQ-002 Parameter: SKIP_W, default 8, width of the skip-nesting counter.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low; asserting (0) clears all state immediately, independent of clk.
REQ-005 instr_valid  input  1  current instruction is real and may update state.
REQ-006 is_open  input  1  current instruction is loop-open '['.
REQ-007 is_close  input  1  current instruction is loop-close ']'.
REQ-008 acc_zero  input  1  accumulator equals zero (from accumulator unit).
REQ-009 pc  input  16  address of the current instruction (PROGRAM_COUNTER).
REQ-010 pc_loaded  output  16  jump target for fetch unit.
REQ-011 pc_take  output  1  fetch shall load pc_loaded this cycle instead of incrementing.
REQ-012 skip  output  1  unit is skipping a zero-entered loop body or faulted; core suppresses all side effects.
REQ-013 depth  output  $clog2(STACK_DEPTH)+1  current return-stack occupancy.
REQ-014 fault  output  1  sticky error: stack overflow, stack underflow or skip-counter overflow.

Function
REQ-015 FSM states: RUN, SKIP, FAULT; skip=1 in SKIP and FAULT, 0 in RUN.
REQ-016 A cycle is active only when instr_valid=1 and exactly one of is_open/is_close is 1; otherwise no state change, pc_take=0.
REQ-017 RUN, open, acc_zero=0, depth<STACK_DEPTH: push pc; depth+1 next cycle; pc_take=0.
REQ-018 RUN, open, acc_zero=1: enter SKIP with skip count=1; no push; pc_take=0.
REQ-019 RUN, close, depth>0, acc_zero=0: pc_take=1, pc_loaded=top+1 (mod 2^16) combinationally same cycle; stack unchanged.
REQ-020 RUN, close, depth>0, acc_zero=1: pop; pc_take=0.
REQ-021 SKIP, open: skip count+1; SKIP, close: skip count-1; count reaching 0 returns to RUN next cycle; stack never touched; acc_zero ignored; pc_take=0.
REQ-022 Open with depth=STACK_DEPTH in RUN, close with depth=0 in RUN, or open with skip count at 2^SKIP_W-1 in SKIP: enter FAULT, fault=1, no stack/counter change.
REQ-023 FAULT is absorbing until reset; pc_take=0 and all inputs ignored.
REQ-024 pc_loaded shall equal top+1 whenever depth>0 and 0 otherwise, independent of pc_take.
REQ-025 pc_take is Mealy (same-cycle); all other outputs are registered, changing only after a clock edge.
REQ-026 Push and pop in one cycle cannot occur; top after pop shall be the previously pushed entry (strict LIFO).

Reset
REQ-027 reset=0: state=RUN, depth=0, skip count=0, fault=0, skip=0, pc_take=0, pc_loaded=0.
REQ-028 Reset mid-skip or mid-fault shall return to RUN within the reset assertion, no clock required.
REQ-029 Stack storage contents need not be cleared; only the pointer is reset.

Structure
REQ-030 loop_state enum (RUN, SKIP, FAULT) and LOOP_STACK_DEPTH default constant belong in the shared definitions package; PROGRAM_COUNTER reused from it.
REQ-031 Storage shall be sub-module loop_stack (LIFO: push, pop, top, count, full, empty); FSM, skip counter and target adder live in loop_unit.

Verification
REQ-032 pc=5 open acc_zero=0, pc=9 close acc_zero=0 -> depth=1, pc_take=1, pc_loaded=6; then close acc_zero=1 -> depth=0.
REQ-033 pc=3 open acc_zero=1, then open, close, close -> skip=1 for 4 cycles' effects, returns RUN after final close; depth stays 0, pc_take never 1.
REQ-034 17 opens with acc_zero=0 (STACK_DEPTH=16) -> depth=16, 17th sets fault=1, skip=1; later close acc_zero=0 -> pc_take=0.
REQ-035 Close at depth=0 in RUN -> fault=1 next cycle; reset low -> fault=0, depth=0 without clock edge.
REQ-036 instr_valid=0 or is_open=is_close=1 with any acc_zero -> no change in depth/state, pc_take=0.
REQ-037 pc=16'hFFFF open, then close acc_zero=0 -> pc_loaded=16'h0000, pc_take=1.
